// File: rtl/i2s_tdm_xcvr_pkg.sv
// i2s_pkg: shared types and constants for the I2S/TDM transceiver.
//   mode_e      : serial framing, I2S (one bit-clock data delay) or left-justified.
//   frame_bits(): bit clocks per frame for a given channel count and slot width.
//   DEF_*       : default widths used by the transceiver parameters.
package i2s_pkg;

    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_LJ  = 1'b1
    } mode_e;

    localparam int DEF_DATA_BIT = 24;
    localparam int DEF_SLOT_BIT = 32;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_SCLK_DIV = 4;

    function automatic int frame_bits(input int ch, input int slot);
        return ch * slot;
    endfunction

endpackage

// File: rtl/i2s_tdm_xcvr_clkgen.sv
// i2s_tdm_clkgen: bit/frame clock generator for the TDM transceiver.
//   clk, reset   : system clock, synchronous active-high reset.
//   sclk, lrclk  : registered bit clock and frame clock.
//   fall_tick    : last clk of an sclk period (sclk falls, TX data changes).
//   rise_tick    : clk before sclk rises (RX data sampled).
//   frame_start  : fall_tick at which the data position wraps to 0.
//   pos          : data position of the bit currently on the line.
module i2s_tdm_clkgen
    import i2s_pkg::*;
#(
    parameter int    SLOT_BIT = DEF_SLOT_BIT,
    parameter int    CHANNELS = DEF_CHANNELS,
    parameter int    SCLK_DIV = DEF_SCLK_DIV,
    parameter mode_e MODE     = MODE_I2S,
    localparam int   FB       = frame_bits(CHANNELS, SLOT_BIT),
    localparam int   BW       = $clog2(FB)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          sclk,
    output logic          lrclk,
    output logic          fall_tick,
    output logic          rise_tick,
    output logic          frame_start,
    output logic [BW-1:0] pos
);
    localparam int HALF = SCLK_DIV / 2;
    localparam int DW   = $clog2(SCLK_DIV);

    logic [DW-1:0] div_cnt, div_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;

    // I2S data trails the frame clock by one bit clock.
    function automatic logic [BW-1:0] to_pos(input logic [BW-1:0] bc);
        if (MODE == MODE_LJ) return bc;
        return (bc == '0) ? BW'(FB - 1) : bc - 1'b1;
    endfunction

    assign fall_tick   = (div_cnt == DW'(SCLK_DIV - 1));
    assign rise_tick   = (div_cnt == DW'(HALF - 1));
    assign div_nxt     = fall_tick ? '0 : div_cnt + 1'b1;
    assign bit_nxt     = (bit_cnt == BW'(FB - 1)) ? '0 : bit_cnt + 1'b1;
    assign pos         = to_pos(bit_cnt);
    assign frame_start = fall_tick && (to_pos(bit_nxt) == '0);

    // sclk/lrclk are computed from the next counter values so the registered
    // outputs line up exactly with div_cnt/bit_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            sclk    <= (div_nxt >= DW'(HALF));
            if (fall_tick) begin
                bit_cnt <= bit_nxt;
                lrclk   <= (bit_nxt >= BW'(FB / 2));
            end
        end
    end

endmodule

// File: rtl/i2s_tdm_xcvr.sv
// i2s_tdm_xcvr: CHANNELS-slot TDM / I2S transceiver in a single clock domain.
//   i_clk_12_288, i_reset     : clock and synchronous active-high reset.
//   i_tx_data/valid, o_tx_ready: TX frame handshake into a one-deep holding register.
//   o_tx_underrun             : pulse when a frame starts with nothing held (zeros sent).
//   o_rx_data, o_rx_valid     : last complete RX frame and its update pulse.
//   o_mclk, o_sclk, o_lrclk   : codec clocks; o_tx_sd / i_rx_sd serial data.
// Optional: define I2S_TDM_LOOPBACK_EN to add i_loopback, which routes o_tx_sd
// into the RX sampler in place of i_rx_sd.
module i2s_tdm_xcvr
    import i2s_pkg::*;
#(
    parameter int    DATA_BIT = DEF_DATA_BIT,
    parameter int    SLOT_BIT = DEF_SLOT_BIT,
    parameter int    CHANNELS = DEF_CHANNELS,
    parameter int    SCLK_DIV = DEF_SCLK_DIV,
    parameter mode_e MODE     = i2s_pkg::MODE_I2S
) (
    input  logic                         i_clk_12_288,
    input  logic                         i_reset,
    input  logic [CHANNELS*DATA_BIT-1:0] i_tx_data,
    input  logic                         i_tx_valid,
    output logic                         o_tx_ready,
    output logic                         o_tx_underrun,
    output logic [CHANNELS*DATA_BIT-1:0] o_rx_data,
    output logic                         o_rx_valid,
    output logic                         o_mclk,
    output logic                         o_sclk,
    output logic                         o_lrclk,
    output logic                         o_tx_sd,
    input  logic                         i_rx_sd
`ifdef I2S_TDM_LOOPBACK_EN
    ,
    input  logic                         i_loopback
`endif
);
    localparam int FB       = frame_bits(CHANNELS, SLOT_BIT);
    localparam int FW       = CHANNELS * DATA_BIT;
    localparam int BW       = $clog2(FB);
    localparam int LAST_POS = (CHANNELS - 1) * SLOT_BIT + DATA_BIT - 1;

    logic          fall_tick, rise_tick, frame_start;
    logic [BW-1:0] pos;

    i2s_tdm_clkgen #(
        .SLOT_BIT (SLOT_BIT),
        .CHANNELS (CHANNELS),
        .SCLK_DIV (SCLK_DIV),
        .MODE     (MODE)
    ) u_clkgen (
        .clk         (i_clk_12_288),
        .reset       (i_reset),
        .sclk        (o_sclk),
        .lrclk       (o_lrclk),
        .fall_tick   (fall_tick),
        .rise_tick   (rise_tick),
        .frame_start (frame_start),
        .pos         (pos)
    );

    assign o_mclk = i_clk_12_288;

    // ---------------- TX ----------------
    logic [FW-1:0] hold_data;
    logic          hold_full;
    logic [FB-1:0] img, load_img, tx_shift;
    logic          xfer;

    assign o_tx_ready = ~hold_full;
    assign xfer       = i_tx_valid && ~hold_full;

    // Line image of the held frame, first bit on the wire at the MSB; pad bits 0.
    for (genvar s = 0; s < CHANNELS; s++) begin : g_tx_slot
        for (genvar b = 0; b < SLOT_BIT; b++) begin : g_tx_bit
            if (b < DATA_BIT) begin : g_data
                assign img[FB-1-(s*SLOT_BIT+b)] = hold_data[s*DATA_BIT+DATA_BIT-1-b];
            end else begin : g_pad
                assign img[FB-1-(s*SLOT_BIT+b)] = 1'b0;
            end
        end
    end

    assign load_img = hold_full ? img : '0;

    // A transfer coinciding with frame_start sees hold_full=0: that frame
    // underruns and the new data waits for the next frame.
    always_ff @(posedge i_clk_12_288) begin
        if (i_reset) begin
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tx_shift      <= '0;
            o_tx_sd       <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            o_tx_underrun <= 1'b0;
            if (xfer) begin
                hold_data <= i_tx_data;
                hold_full <= 1'b1;
            end
            if (frame_start) begin
                o_tx_sd  <= load_img[FB-1];
                tx_shift <= load_img << 1;
                if (hold_full) hold_full     <= 1'b0;
                else           o_tx_underrun <= 1'b1;
            end else if (fall_tick) begin
                o_tx_sd  <= tx_shift[FB-1];
                tx_shift <= tx_shift << 1;
            end
        end
    end

    // ---------------- RX ----------------
    logic          rx_in;
    logic [FW-1:0] rx_shadow, rx_next, rx_hit;
    logic          rx_last;

`ifdef I2S_TDM_LOOPBACK_EN
    assign rx_in = i_loopback ? o_tx_sd : i_rx_sd;
`else
    assign rx_in = i_rx_sd;
`endif

    // One-hot write enable per data bit; pad positions never match.
    for (genvar s = 0; s < CHANNELS; s++) begin : g_rx_slot
        for (genvar b = 0; b < DATA_BIT; b++) begin : g_rx_bit
            assign rx_hit[s*DATA_BIT+DATA_BIT-1-b] = (pos == BW'(s*SLOT_BIT+b));
        end
    end

    assign rx_next = (rx_shadow & ~rx_hit) | (rx_hit & {FW{rx_in}});
    assign rx_last = (pos == BW'(LAST_POS));

    always_ff @(posedge i_clk_12_288) begin
        if (i_reset) begin
            rx_shadow  <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= rise_tick && rx_last;
            if (rise_tick) begin
                rx_shadow <= rx_next;
                if (rx_last) o_rx_data <= rx_next;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_xcvr.sv
module tb_i2s_tdm_xcvr;
    import i2s_pkg::*;

    localparam int DB = 24, SB = 32, FB = 64, FW = 48, FW4 = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int ntest = 0;
    int nfail = 0;

    // Default instance: 2 channels, I2S
    logic [FW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, underrun, rx_valid, mclk, sclk, lrclk, tx_sd, rx_sd;
    logic [FW-1:0] rx_data;
    logic          ext_lb = 1'b0;
    logic          rx_level = 1'b0;
    assign rx_sd = ext_lb ? tx_sd : rx_level;
`ifdef I2S_TDM_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    i2s_tdm_xcvr dut (
        .i_clk_12_288 (clk),
        .i_reset      (rst),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_tx_underrun(underrun),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_mclk       (mclk),
        .o_sclk       (sclk),
        .o_lrclk      (lrclk),
        .o_tx_sd      (tx_sd),
        .i_rx_sd      (rx_sd)
`ifdef I2S_TDM_LOOPBACK_EN
        ,
        .i_loopback   (loopback)
`endif
    );

    // Second instance: 4 channels, left-justified, external loopback
    logic [FW4-1:0] tx_data4 = '0;
    logic           tx_valid4 = 1'b0;
    logic           tx_ready4, underrun4, rx_valid4, mclk4, sclk4, lrclk4, tx_sd4;
    logic [FW4-1:0] rx_data4;

    i2s_tdm_xcvr #(.CHANNELS(4), .MODE(MODE_LJ)) dut4 (
        .i_clk_12_288 (clk),
        .i_reset      (rst),
        .i_tx_data    (tx_data4),
        .i_tx_valid   (tx_valid4),
        .o_tx_ready   (tx_ready4),
        .o_tx_underrun(underrun4),
        .o_rx_data    (rx_data4),
        .o_rx_valid   (rx_valid4),
        .o_mclk       (mclk4),
        .o_sclk       (sclk4),
        .o_lrclk      (lrclk4),
        .o_tx_sd      (tx_sd4),
        .i_rx_sd      (tx_sd4)
`ifdef I2S_TDM_LOOPBACK_EN
        ,
        .i_loopback   (1'b0)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference receiver for the default instance: decodes the TX line from
    // sclk/lrclk alone, plus clock period measurement and event capture.
    int  cyc = 0, t_sr = 0, t_lr = 0, t_lf = 0;
    int  sclk_per = 0, lr_per = 0, lr_low = 0, ucnt = 0;
    logic sclk_q = 1'b0, lr_q = 1'b0, lr_at_rise = 1'b0;
    int  k = -1, nb = 0;
    bit  infr = 1'b0;
    bit  line [FB];
    logic [FW-1:0] dfr;
    bit  dok;
    logic [FW-1:0] dec_q[$];
    bit            pad_q[$];
    logic [FW-1:0] rx_q[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (underrun) ucnt++;
            if (rx_valid) rx_q.push_back(rx_data);
            if (lrclk && !lr_q) begin
                if (t_lr > 0) lr_per = cyc - t_lr;
                if (t_lf > 0) lr_low = cyc - t_lf;
                t_lr = cyc;
            end
            if (!lrclk && lr_q) t_lf = cyc;
            if (sclk && !sclk_q) begin
                if (t_sr > 0) sclk_per = cyc - t_sr;
                t_sr = cyc;
                if (lr_at_rise && !lrclk) k = 0;
                else if (k >= 0) k++;
                lr_at_rise = lrclk;
                if (k >= 0) begin
                    // I2S: line position lags the bit clock count by one
                    if ((k + FB - 1) % FB == 0) begin
                        infr = 1'b1;
                        nb   = 0;
                    end
                    if (infr) begin
                        line[nb] = tx_sd;
                        nb++;
                        if (nb == FB) begin
                            dfr = '0;
                            dok = 1'b1;
                            for (int s = 0; s < 2; s++)
                                for (int b = 0; b < SB; b++)
                                    if (b < DB) dfr[s*DB+DB-1-b] = line[s*SB+b];
                                    else if (line[s*SB+b]) dok = 1'b0;
                            dec_q.push_back(dfr);
                            pad_q.push_back(dok);
                            infr = 1'b0;
                        end
                    end
                end
            end
        end
        sclk_q = sclk;
        lr_q   = lrclk;
    end

    task automatic wait_lr_fall(input int n);
        int   seen = 0;
        int   budget = 0;
        logic prev = lrclk;
        while (seen < n && budget < 300 * n) begin
            @(negedge clk);
            budget++;
            if (prev && !lrclk) seen++;
            prev = lrclk;
        end
        chk("lrclk_fall_timeout", seen, n);
    endtask

    task automatic send(input logic [FW-1:0] f);
        tx_data  = f;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [FW-1:0]  f, got;
        logic [FW4-1:0] exp4[$];
        int  idx, cnt, nrv, pre, matched, nfall;
        bit  hit, started, rdy_seen, lr4_prev;

        // Reset
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_sclk", sclk, 1'b0);
            chk("rst_lrclk", lrclk, 1'b0);
        end
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, '0);
        chk("rst_tx_sd", tx_sd, 1'b0);
        rst = 1'b0;

        // Clock periods
        wait_lr_fall(2);
        chk("sclk_period", sclk_per, 4);
        chk("lrclk_period", lr_per, 256);
        chk("lrclk_low", lr_low, 128);

        // I2S TX of L=A5A5A5 R=5A5A5A, with RX looped externally
        ext_lb = 1'b1;
        repeat ($urandom_range(10, 100)) @(negedge clk);
        dec_q.delete(); pad_q.delete(); rx_q.delete();
        f = {24'h5A5A5A, 24'hA5A5A5};
        chk("a5_ready", tx_ready, 1'b1);
        send(f);
        chk("a5_ready_drop", tx_ready, 1'b0);
        wait_lr_fall(4);
        idx = -1;
        foreach (dec_q[i]) if (idx < 0 && dec_q[i] != '0) idx = i;
        got = (idx >= 0) ? dec_q[idx] : '0;
        chk("a5_line_frame", got, f);
        chk("a5_latency", (idx >= 0 && idx <= 2), 1'b1);
        cnt = 0;
        foreach (pad_q[i]) if (!pad_q[i]) cnt++;
        chk("a5_pad_zero", cnt, 0);
        hit = 1'b0;
        foreach (rx_q[i]) if (rx_q[i] === f) hit = 1'b1;
        chk("a5_rx_frame", hit, 1'b1);

        // No more transfers: one underrun and an all-zero frame per frame
        ucnt = 0;
        dec_q.delete();
        wait_lr_fall(3);
        chk("underrun_count", ucnt, 3);
        chk("underrun_frames", dec_q.size(), 3);
        cnt = 0;
        foreach (dec_q[i]) if (dec_q[i] != '0) cnt++;
        chk("underrun_zero_data", cnt, 0);

        // Transfer on the same clk as frame_start (one sclk after lrclk falls)
        repeat (3) @(negedge clk);
        f = {16'($urandom), $urandom};
        f[0] = 1'b1;
        send(f);
        chk("coinc_underrun", underrun, 1'b1);
        chk("coinc_held", tx_ready, 1'b0);
        dec_q.delete();
        wait_lr_fall(3);
        chk("coinc_nframes", dec_q.size() >= 2, 1'b1);
        got = (dec_q.size() >= 1) ? dec_q[0] : '1;
        chk("coinc_first_zero", got, '0);
        got = (dec_q.size() >= 2) ? dec_q[1] : '0;
        chk("coinc_next_data", got, f);

        // 4-channel LJ external loopback with continuous random frames
        tx_data4  = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
        tx_valid4 = 1'b1;
        rdy_seen  = tx_ready4;
        lr4_prev  = lrclk4;
        nrv = 0; pre = 0; matched = 0; nfall = 0; started = 1'b0;
        for (int c = 0; c < 8 * 512 + 600 && nfall < 8; c++) begin
            @(negedge clk);
            if (rdy_seen) begin
                exp4.push_back(tx_data4);
                tx_data4 = {$urandom, $urandom, $urandom};
                tx_data4[0] = 1'b1;
            end
            rdy_seen = tx_ready4;
            if (lr4_prev && !lrclk4) nfall++;
            lr4_prev = lrclk4;
            if (rx_valid4) begin
                if (nfall >= 1) nrv++;
                if (!started && exp4.size() > 0 && rx_data4 === exp4[0]) started = 1'b1;
                if (started) begin
                    chk("lb4_frame", rx_data4, exp4.pop_front());
                    matched++;
                end else pre++;
            end
        end
        tx_valid4 = 1'b0;
        chk("lb4_fall_timeout", nfall, 8);
        chk("lb4_rx_valid_per_frame", nrv, 7);
        chk("lb4_latency", pre <= 2, 1'b1);
        chk("lb4_matched", matched >= 4, 1'b1);

`ifdef I2S_TDM_LOOPBACK_EN
        // Internal loopback overrides an all-ones RX line
        @(negedge clk);
        ext_lb   = 1'b0;
        rx_level = 1'b1;
        loopback = 1'b1;
        rx_q.delete();
        f = {16'($urandom), $urandom};
        f[0] = 1'b1;
        chk("int_lb_ready", tx_ready, 1'b1);
        send(f);
        wait_lr_fall(4);
        hit = 1'b0;
        cnt = 0;
        foreach (rx_q[i]) begin
            if (rx_q[i] === f) hit = 1'b1;
            if (rx_q[i] === '1) cnt++;
        end
        chk("int_lb_frame", hit, 1'b1);
        chk("int_lb_not_ones", cnt, 0);
        loopback = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_xcvr.md
Name: i2s_tdm_xcvr

Overview:
- Parametrised successor of the fixed stereo I2S transceiver: one clock domain, CHANNELS-slot TDM frame, configurable sample/slot width, I2S or left-justified framing.
- Generates MCLK/SCLK/LRCLK, serialises a TX frame and deserialises an RX frame, with a valid/ready TX handshake and underrun flag.
- Sits between the audio codec pins and the DSP/datapath at 12.288 MHz.

Parameters:
- DATA_BIT, 24, sample width per channel (<= SLOT_BIT).
- SLOT_BIT, 32, sclk periods per slot; trailing SLOT_BIT-DATA_BIT bits padded with 0.
- CHANNELS, 2, slots per frame; even, >= 2.
- SCLK_DIV, 4, clk cycles per sclk period; even, >= 2.
- MODE, i2s_pkg::MODE_I2S, MODE_I2S (1-sclk data delay after LRCLK edge) or MODE_LJ (no delay).

Ports:
- i_clk_12_288  in  1  sole clock, 12.288 MHz.
- i_reset  in  1  synchronous, active-high reset.
- i_tx_data  in  CHANNELS*DATA_BIT  TX frame; channel k at [k*DATA_BIT +: DATA_BIT].
- i_tx_valid  in  1  TX frame offered.
- o_tx_ready  out  1  TX holding register empty.
- o_tx_underrun  out  1  1-clk pulse: frame started with no frame held.
- o_rx_data  out  CHANNELS*DATA_BIT  last complete RX frame, same packing.
- o_rx_valid  out  1  1-clk pulse when o_rx_data updates.
- o_mclk  out  1  i_clk_12_288 forwarded.
- o_sclk  out  1  bit clock.
- o_lrclk  out  1  frame/word clock.
- o_tx_sd  out  1  serial TX data.
- i_rx_sd  in  1  serial RX data.

Behaviour:
- Reset: div_cnt=0, bit_cnt=0, o_sclk=0, o_lrclk=0, o_tx_sd=0, o_tx_ready=1, o_tx_underrun=0, o_rx_valid=0, o_rx_data=0, shift/holding registers=0. Reset mid-frame aborts the frame; no rx_valid is issued for it.
- FRAME_BITS = CHANNELS*SLOT_BIT. div_cnt counts 0..SCLK_DIV-1 and wraps. o_sclk = (div_cnt >= SCLK_DIV/2), registered.
- fall_tick: div_cnt==SCLK_DIV-1. rise_tick: div_cnt==SCLK_DIV/2-1.
- bit_cnt (0..FRAME_BITS-1, wraps) advances on fall_tick. o_lrclk = (bit_cnt >= FRAME_BITS/2), updated on fall_tick. For CHANNELS=2 this is standard L=0/R=1.
- Data position p = (bit_cnt - D) mod FRAME_BITS, with D=1 for I2S and D=0 for LJ. Slot s = p / SLOT_BIT; bit b = p % SLOT_BIT. For b < DATA_BIT the line carries bit DATA_BIT-1-b of channel s (MSB first); otherwise 0.
- TX: o_tx_sd is updated on fall_tick. frame_start is the fall_tick at which p becomes 0.
  - At frame_start, if the holding register is full, it is copied into the shift register and o_tx_ready rises next clk.
  - If the holding register is empty, the shift register loads zeros and o_tx_underrun pulses.
- Handshake: a transfer occurs on a clk with i_tx_valid && o_tx_ready; the holding register latches and o_tx_ready drops next clk.
  - If a transfer and frame_start coincide, frame_start uses the old (empty) state: underrun pulses, and the new data is held for the next frame.
- RX: i_rx_sd is sampled on rise_tick into the slot/bit addressed by p. Pad bits are ignored.
  - On the rise_tick sampling the last data bit of slot CHANNELS-1, o_rx_data updates on the next clk and o_rx_valid pulses 1 clk.
- Latency: transfer to first TX bit on the line is <= 2 frames. RX last bit to o_rx_valid is 1 clk.

Optional Feature:
- I2S_TDM_LOOPBACK_EN defined: adds input i_loopback. When it is 1, the RX path samples the internal o_tx_sd instead of i_rx_sd, so the RX frame equals the TX frame and the timing is unchanged. When it is 0, operation is normal.
- Undefined: no i_loopback port; RX always samples i_rx_sd.

Decomposition:
- i2s_pkg: mode_e {MODE_I2S, MODE_LJ}; function frame_bits(ch, slot); default width constants.
- Sub-module i2s_tdm_clkgen: div_cnt, bit_cnt, o_sclk, o_lrclk, fall_tick, rise_tick, frame_start, data position p. i2s_tdm_xcvr adds the TX/RX datapath and handshake.

Test Plan:
- Defaults, i_reset=1 for 3 clk, then released -> o_sclk=0 and o_lrclk=0 during reset; o_sclk period 4 clk; o_lrclk period 256 clk (48 kHz); o_lrclk low for 128 clk.
- Defaults, I2S mode, TX L=24'hA5A5A5, R=24'h5A5A5A -> o_tx_sd shows A5A5A5 MSB-first starting 1 sclk after o_lrclk falls, then 8 zeros; R follows after o_lrclk rises.
- External loopback i_rx_sd=o_tx_sd, MODE_LJ, CHANNELS=4, tx frame {24'h000004, 24'h000003, 24'h000002, 24'h000001} -> o_rx_valid once per frame and o_rx_data matches from the second frame onward.
- i_tx_valid held 0 after one transfer -> o_tx_underrun pulses once per subsequent frame; o_tx_sd is all zeros in those frames.
- Transfer asserted on the same clk as frame_start -> underrun pulses; the data appears in the following frame.
- I2S_TDM_LOOPBACK_EN, i_loopback=1, i_rx_sd=1 -> o_rx_data equals the TX frame, not all-ones.
